// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: samples the divided count/adjust clock levels,
// detects their rising edges and keeps an MM:SS count as four BCD digits with
// run/pause, clear and manual minute/second adjust.
module stopwatch_counter #(
   parameter int MIN_MAX      = 59,
   parameter bit RUN_ON_RESET = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       sec_clk_in,
   input  logic       adj_clk_in,
   input  logic       pause_p,
   input  logic       clear_p,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       rollover
);

   localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
   localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

   typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

   state_t state;
   logic   sec_prev;
   logic   adj_prev;
   logic   sec_tick;
   logic   adj_tick;
   logic   sec_at_max;
   logic   min_at_max;

   // Minutes +1 as a BCD pair; wraps MIN_MAX -> 00, illegal values snap to 00.
   function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] o);
      if (t > 4'd9 || o > 4'd9 || {t, o} >= {MAX_TENS, MAX_ONES})
         return 8'h00;
      else if (o == 4'd9)
         return {t + 4'd1, 4'd0};
      else
         return {t, o + 4'd1};
   endfunction

   // Seconds +1 as a BCD pair; wraps 59 -> 00, illegal values snap to 00.
   function automatic logic [7:0] inc_sec(input logic [3:0] t, input logic [3:0] o);
      if (t > 4'd5 || o > 4'd9 || {t, o} == 8'h59)
         return 8'h00;
      else if (o == 4'd9)
         return {t + 4'd1, 4'd0};
      else
         return {t, o + 4'd1};
   endfunction

   // Rising-edge strobes and terminal-count flags for the current cycle.
   always_comb begin
      sec_tick   = sec_clk_in & ~sec_prev;
      adj_tick   = adj_clk_in & ~adj_prev;
      sec_at_max = ({sec_tens, sec_ones} == 8'h59);
      min_at_max = ({min_tens, min_ones} == {MAX_TENS, MAX_ONES});
   end

   // Level history; resets high so a level already high after reset is not a tick.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sec_prev <= 1'b1;
         adj_prev <= 1'b1;
      end else begin
         sec_prev <= sec_clk_in;
         adj_prev <= adj_clk_in;
      end
   end

   // RUN/PAUSED state: only pause_p toggles it; running mirrors the new state.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN_ON_RESET ? RUN : PAUSED;
         running <= RUN_ON_RESET;
      end else if (pause_p) begin
         state   <= (state == RUN) ? PAUSED : RUN;
         running <= (state != RUN);
      end
   end

   // Digit update: clear wins, then ticks judged against the pre-toggle state.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         {min_tens, min_ones} <= 8'h00;
         {sec_tens, sec_ones} <= 8'h00;
         rollover             <= 1'b0;
      end else begin
         rollover <= 1'b0;
         if (clear_p) begin
            {min_tens, min_ones} <= 8'h00;
            {sec_tens, sec_ones} <= 8'h00;
         end else if (state == RUN) begin
            if (adj) begin
               if (adj_tick) begin
                  if (sel)
                     {sec_tens, sec_ones} <= inc_sec(sec_tens, sec_ones);
                  else
                     {min_tens, min_ones} <= inc_min(min_tens, min_ones);
               end
            end else if (sec_tick) begin
               {sec_tens, sec_ones} <= inc_sec(sec_tens, sec_ones);
               if (sec_at_max) begin
                  {min_tens, min_ones} <= inc_min(min_tens, min_ones);
                  rollover             <= min_at_max;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter (MIN_MAX=59, RUN_ON_RESET=1).
module tb_stopwatch_counter;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       sec_clk_in;
   logic       adj_clk_in;
   logic       pause_p;
   logic       clear_p;
   logic       adj;
   logic       sel;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       rollover;

   int total = 0;
   int bad   = 0;
   int roll_cnt = 0;
   logic [15:0] mmss;

   stopwatch_counter #(.MIN_MAX(59), .RUN_ON_RESET(1'b1)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .sec_clk_in (sec_clk_in),
      .adj_clk_in (adj_clk_in),
      .pause_p    (pause_p),
      .clear_p    (clear_p),
      .adj        (adj),
      .sel        (sel),
      .min_tens   (min_tens),
      .min_ones   (min_ones),
      .sec_tens   (sec_tens),
      .sec_ones   (sec_ones),
      .running    (running),
      .rollover   (rollover)
   );

   always #5 clk_in = ~clk_in;

   assign mmss = {min_tens, min_ones, sec_tens, sec_ones};

   // Count cycles in which rollover is high, sampled away from the active edge.
   always @(negedge clk_in) if (rst_n && rollover) roll_cnt++;

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // One rising edge on sec_clk_in, then back low; ends on a negedge.
   task automatic sec_edges(input int n);
      repeat (n) begin
         sec_clk_in = 1'b1;
         @(negedge clk_in);
         sec_clk_in = 1'b0;
         @(negedge clk_in);
      end
   endtask

   task automatic adj_edges(input int n);
      repeat (n) begin
         adj_clk_in = 1'b1;
         @(negedge clk_in);
         adj_clk_in = 1'b0;
         @(negedge clk_in);
      end
   endtask

   task automatic pulse_pause();
      pause_p = 1'b1;
      @(negedge clk_in);
      pause_p = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic pulse_clear();
      clear_p = 1'b1;
      @(negedge clk_in);
      clear_p = 1'b0;
      @(negedge clk_in);
   endtask

   // Clear, then load MM:SS through adjust mode, leaving adj=0.
   task automatic preload(input int mm, input int ss);
      pulse_clear();
      adj = 1'b1;
      sel = 1'b0;
      adj_edges(mm);
      sel = 1'b1;
      adj_edges(ss);
      adj = 1'b0;
      sel = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sec_clk_in = 1'b0; adj_clk_in = 1'b0;
      pause_p = 1'b0; clear_p = 1'b0; adj = 1'b0; sel = 1'b0;
      idle(2);
      total++;
      if (mmss !== 16'h0000 || running !== 1'b1 || rollover !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got mmss=%h run=%b roll=%b want 0000/1/0", mmss, running, rollover);
      end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_count_minute();
      int r0;
      r0 = roll_cnt;
      sec_edges(10);
      total++;
      if (mmss !== 16'h0010) begin
         bad++;
         $display("FAIL count_10: got %h want 0010", mmss);
      end
      sec_edges(50);
      total++;
      if (mmss !== 16'h0100 || running !== 1'b1) begin
         bad++;
         $display("FAIL count_60: got %h run=%b want 0100 run=1", mmss, running);
      end
      total++;
      if (roll_cnt != r0) begin
         bad++;
         $display("FAIL count_no_roll: got %0d rollover cycles want 0", roll_cnt - r0);
      end
   endtask

   task automatic test_rollover();
      int r0;
      preload(59, 59);
      total++;
      if (mmss !== 16'h5959) begin
         bad++;
         $display("FAIL preload_5959: got %h want 5959", mmss);
      end
      r0 = roll_cnt;
      sec_clk_in = 1'b1;
      @(negedge clk_in);
      total++;
      if (mmss !== 16'h0000 || rollover !== 1'b1) begin
         bad++;
         $display("FAIL rollover_wrap: got %h roll=%b want 0000 roll=1", mmss, rollover);
      end
      sec_clk_in = 1'b0;
      @(negedge clk_in);
      total++;
      if (rollover !== 1'b0 || roll_cnt - r0 != 1) begin
         bad++;
         $display("FAIL rollover_width: got roll=%b cycles=%0d want 0 and 1", rollover, roll_cnt - r0);
      end
   endtask

   task automatic test_pause();
      pulse_pause();
      total++;
      if (running !== 1'b0) begin
         bad++;
         $display("FAIL pause_state: got running=%b want 0", running);
      end
      sec_edges(5);
      total++;
      if (mmss !== 16'h0000) begin
         bad++;
         $display("FAIL pause_hold: got %h want 0000", mmss);
      end
      pulse_pause();
      sec_edges(1);
      total++;
      if (mmss !== 16'h0001 || running !== 1'b1) begin
         bad++;
         $display("FAIL resume: got %h run=%b want 0001 run=1", mmss, running);
      end
   endtask

   task automatic test_adjust();
      int r0;
      r0 = roll_cnt;
      preload(5, 58);
      adj = 1'b1;
      sel = 1'b1;
      adj_edges(3);
      total++;
      if (mmss !== 16'h0501) begin
         bad++;
         $display("FAIL adj_sec_wrap: got %h want 0501", mmss);
      end
      sec_edges(2);
      total++;
      if (mmss !== 16'h0501) begin
         bad++;
         $display("FAIL adj_ignores_sec: got %h want 0501", mmss);
      end
      sel = 1'b0;
      adj_edges(54);
      total++;
      if (mmss !== 16'h5901) begin
         bad++;
         $display("FAIL adj_min_59: got %h want 5901", mmss);
      end
      adj_edges(3);
      total++;
      if (mmss !== 16'h0201 || roll_cnt != r0) begin
         bad++;
         $display("FAIL adj_min_wrap: got %h roll_cycles=%0d want 0201 and 0", mmss, roll_cnt - r0);
      end
      adj = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_clear_priority();
      preload(12, 34);
      sec_clk_in = 1'b1;
      clear_p    = 1'b1;
      @(negedge clk_in);
      sec_clk_in = 1'b0;
      clear_p    = 1'b0;
      @(negedge clk_in);
      total++;
      if (mmss !== 16'h0000 || running !== 1'b1) begin
         bad++;
         $display("FAIL clear_over_tick: got %h run=%b want 0000 run=1", mmss, running);
      end
      sec_edges(1);
      total++;
      if (mmss !== 16'h0001) begin
         bad++;
         $display("FAIL after_clear: got %h want 0001", mmss);
      end
   endtask

   task automatic test_back_to_back();
      // Tick plus pause in the same cycle: increment, then PAUSED.
      sec_clk_in = 1'b1;
      pause_p    = 1'b1;
      @(negedge clk_in);
      sec_clk_in = 1'b0;
      pause_p    = 1'b0;
      @(negedge clk_in);
      total++;
      if (mmss !== 16'h0002 || running !== 1'b0) begin
         bad++;
         $display("FAIL tick_with_pause: got %h run=%b want 0002 run=0", mmss, running);
      end
      // Clear while paused keeps PAUSED.
      pulse_clear();
      total++;
      if (mmss !== 16'h0000 || running !== 1'b0) begin
         bad++;
         $display("FAIL clear_paused: got %h run=%b want 0000 run=0", mmss, running);
      end
      pulse_pause();
      // Both levels rise together with adj=0: only the sec tick counts.
      sec_clk_in = 1'b1;
      adj_clk_in = 1'b1;
      @(negedge clk_in);
      sec_clk_in = 1'b0;
      adj_clk_in = 1'b0;
      @(negedge clk_in);
      total++;
      if (mmss !== 16'h0001) begin
         bad++;
         $display("FAIL both_ticks: got %h want 0001", mmss);
      end
   endtask

   task automatic test_async_reset();
      preload(7, 42);
      total++;
      if (mmss !== 16'h0742) begin
         bad++;
         $display("FAIL preload_0742: got %h want 0742", mmss);
      end
      @(posedge clk_in);
      #2;
      rst_n      = 1'b0;
      sec_clk_in = 1'b1;
      #1;
      total++;
      if (mmss !== 16'h0000 || running !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: got %h run=%b want 0000 run=1", mmss, running);
      end
      @(negedge clk_in);
      rst_n = 1'b1;
      idle(3);
      total++;
      if (mmss !== 16'h0000) begin
         bad++;
         $display("FAIL release_high_level: got %h want 0000", mmss);
      end
      sec_clk_in = 1'b0;
      @(negedge clk_in);
      sec_edges(1);
      total++;
      if (mmss !== 16'h0001) begin
         bad++;
         $display("FAIL first_edge_after_reset: got %h want 0001", mmss);
      end
   endtask

   initial begin
      test_reset();
      test_count_minute();
      test_rollover();
      test_pause();
      test_adjust();
      test_clear_priority();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
